adpll_gain_scheduler: RTL and testbench

//  Sequences the RingADPLL through reset, acquisition and tracking.

---
 rtl/adpll_gain_scheduler.sv | 154 +++++++++++++++
 tb/tb_adpll_gain_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/adpll_gain_scheduler.sv
// Gain and sequencing controller for the RingADPLL: IDLE -> RESET -> ACQUIRE <-> TRACK.
// Define ADPLL_RELOCK_CNT_EN to add the saturating relock counter output relock_cnt_o.
module adpll_gain_scheduler #(
  parameter int unsigned LOCK_THRESH   = 2,
  parameter int unsigned UNLOCK_THRESH = 8,
  parameter int unsigned LOCK_COUNT    = 64,
  parameter int unsigned UNLOCK_COUNT  = 4,
  parameter int unsigned ACQ_TIMEOUT   = 4096,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned CNT_WIDTH     = 13
) (
  input  logic       fpga_clk_i,
  input  logic       rst_pbn_i,
  input  logic       enable_i,
  input  logic       ref_clk_i,
  input  logic [7:0] error_i,
  input  logic [5:0] kp_acq_i,
  input  logic [4:0] ki_acq_i,
  input  logic [5:0] kp_trk_i,
  input  logic [4:0] ki_trk_i,
  output logic [5:0] kp_o,
  output logic [4:0] ki_o,
  output logic       adpll_enable_o,
  output logic       adpll_reset_o,
  output logic       locked_o,
  output logic [1:0] state_o
`ifdef ADPLL_RELOCK_CNT_EN
  ,
  output logic [7:0] relock_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_ACQ   = 2'd2,
    S_TRACK = 2'd3
  } state_e;

  localparam logic [7:0]           LOCK_TH   = 8'(LOCK_THRESH);
  localparam logic [7:0]           UNLOCK_TH = 8'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] UNL_LAST  = CNT_WIDTH'(UNLOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(ACQ_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST  = CNT_WIDTH'(RST_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 ref_q;
  logic [CNT_WIDTH-1:0] lock_q, lock_d, unl_q, unl_d, tmo_q, tmo_d;
  logic [5:0]           kp_q;
  logic [4:0]           ki_q;
  logic                 en_q, rst_q, locked_q;

  logic       strb;
  logic [7:0] abs_err;
  logic       in_lock, out_lock;

  assign strb     = ref_clk_i & ~ref_q;
  // Two's-complement magnitude kept at 8 bits so -128 maps to 128.
  assign abs_err  = error_i[7] ? 8'(~error_i + 8'd1) : error_i;
  assign in_lock  = (abs_err <= LOCK_TH);
  assign out_lock = (abs_err > UNLOCK_TH);

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unl_d   = unl_q;
    tmo_d   = tmo_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_RESET;
        S_RESET: begin
          if (tmo_q == RST_LAST) state_d = S_ACQ;
          else                   tmo_d = tmo_q + 1'b1;
        end
        S_ACQ: begin
          if (strb) begin
            if (in_lock && (lock_q == LOCK_LAST)) begin
              state_d = S_TRACK;
            end else if (tmo_q == TMO_LAST) begin
              state_d = S_RESET;
            end else begin
              lock_d = in_lock ? lock_q + 1'b1 : '0;
              tmo_d  = tmo_q + 1'b1;
            end
          end
        end
        S_TRACK: begin
          if (strb) begin
            if (out_lock && (unl_q == UNL_LAST)) state_d = S_ACQ;
            else unl_d = out_lock ? unl_q + 1'b1 : '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Any state change, including the forced return to IDLE, starts counters afresh.
    if (state_d != state_q || !enable_i) begin
      lock_d = '0;
      unl_d  = '0;
      tmo_d  = '0;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      state_q  <= S_IDLE;
      ref_q    <= 1'b0;
      lock_q   <= '0;
      unl_q    <= '0;
      tmo_q    <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      en_q     <= 1'b0;
      rst_q    <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_clk_i;
      lock_q   <= lock_d;
      unl_q    <= unl_d;
      tmo_q    <= tmo_d;
      // Outputs decode the state being entered so they line up with state_o.
      case (state_d)
        S_IDLE:  begin kp_q <= '0;       ki_q <= '0;       en_q <= 1'b0; rst_q <= 1'b1; locked_q <= 1'b0; end
        S_RESET: begin kp_q <= kp_acq_i; ki_q <= ki_acq_i; en_q <= 1'b0; rst_q <= 1'b1; locked_q <= 1'b0; end
        S_ACQ:   begin kp_q <= kp_acq_i; ki_q <= ki_acq_i; en_q <= 1'b1; rst_q <= 1'b0; locked_q <= 1'b0; end
        default: begin kp_q <= kp_trk_i; ki_q <= ki_trk_i; en_q <= 1'b1; rst_q <= 1'b0; locked_q <= 1'b1; end
      endcase
    end
  end

`ifdef ADPLL_RELOCK_CNT_EN
  logic [7:0] relock_q;

  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i)                                            relock_q <= '0;
    else if (!enable_i)                                        relock_q <= '0;
    else if (state_q == S_TRACK && state_d == S_ACQ && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
  end

  assign relock_cnt_o = relock_q;
`endif

  assign kp_o           = kp_q;
  assign ki_o           = ki_q;
  assign adpll_enable_o = en_q;
  assign adpll_reset_o  = rst_q;
  assign locked_o       = locked_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Directed bench for adpll_gain_scheduler with shortened lock/unlock/timeout/reset counts.
module tb_adpll_gain_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ref_clk = 1'b0;
  logic [7:0] err = 8'd0;
  logic [5:0] kp_acq = 6'h15, kp_trk = 6'h05;
  logic [4:0] ki_acq = 5'h0A, ki_trk = 5'h03;
  logic [5:0] kp;
  logic [4:0] ki;
  logic       en_o, rst_o, locked;
  logic [1:0] state;
`ifdef ADPLL_RELOCK_CNT_EN
  logic [7:0] relock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #2 clk = ~clk;

  adpll_gain_scheduler #(
    .LOCK_COUNT(4), .UNLOCK_COUNT(2), .ACQ_TIMEOUT(16), .RST_CYCLES(3)
  ) dut (
    .fpga_clk_i(clk), .rst_pbn_i(rst_n), .enable_i(enable), .ref_clk_i(ref_clk),
    .error_i(err), .kp_acq_i(kp_acq), .ki_acq_i(ki_acq), .kp_trk_i(kp_trk), .ki_trk_i(ki_trk),
    .kp_o(kp), .ki_o(ki), .adpll_enable_o(en_o), .adpll_reset_o(rst_o),
    .locked_o(locked), .state_o(state)
`ifdef ADPLL_RELOCK_CNT_EN
    , .relock_cnt_o(relock)
`endif
  );

  task automatic strobe(input logic [7:0] e);
    err = e;
    ref_clk = 1'b1;
    @(negedge clk);
    ref_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (kp !== 6'd0 || ki !== 5'd0) begin n_err++; $display("FAIL reset_gains: got %h/%h want 0/0", kp, ki); end
    n_cmp++; if (rst_o !== 1'b1 || en_o !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: got rst=%b en=%b lk=%b want 1 0 0", rst_o, en_o, locked); end
`ifdef ADPLL_RELOCK_CNT_EN
    n_cmp++; if (relock !== 8'd0) begin n_err++; $display("FAIL reset_relock: got %0d want 0", relock); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_enable;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (state !== 2'd1 || rst_o !== 1'b1 || en_o !== 1'b0) begin n_err++; $display("FAIL rst_phase%0d: got st=%0d rst=%b en=%b want 1 1 0", i, state, rst_o, en_o); end
      n_cmp++; if (kp !== 6'h15 || ki !== 5'h0A) begin n_err++; $display("FAIL rst_gain%0d: got %h/%h want 15/0a", i, kp, ki); end
    end
    @(negedge clk);
    n_cmp++; if (state !== 2'd2 || en_o !== 1'b1 || rst_o !== 1'b0) begin n_err++; $display("FAIL acq_entry: got st=%0d en=%b rst=%b want 2 1 0", state, en_o, rst_o); end
  endtask

  task automatic test_lock;
    strobe(8'd1); strobe(8'd1); strobe(8'd3);
    strobe(8'd1); strobe(8'd1); strobe(8'd1);
    n_cmp++; if (state !== 2'd2 || locked !== 1'b0) begin n_err++; $display("FAIL lock_restart: got st=%0d lk=%b want 2 0", state, locked); end
    strobe(8'd1);
    n_cmp++; if (state !== 2'd3 || locked !== 1'b1) begin n_err++; $display("FAIL lock_track: got st=%0d lk=%b want 3 1", state, locked); end
    n_cmp++; if (kp !== 6'h05 || ki !== 5'h03 || en_o !== 1'b1 || rst_o !== 1'b0) begin n_err++; $display("FAIL lock_gains: got %h/%h en=%b rst=%b want 05/03 1 0", kp, ki, en_o, rst_o); end
  endtask

  task automatic test_unlock;
    strobe(8'h80); strobe(8'd0); strobe(8'd8); strobe(8'd8);
    n_cmp++; if (state !== 2'd3 || locked !== 1'b1) begin n_err++; $display("FAIL unlock_hold: got st=%0d lk=%b want 3 1", state, locked); end
    strobe(8'd9);
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL unlock_one: got %0d want 3", state); end
    strobe(8'h80);
    n_cmp++; if (state !== 2'd2 || locked !== 1'b0) begin n_err++; $display("FAIL unlock_acq: got st=%0d lk=%b want 2 0", state, locked); end
    n_cmp++; if (kp !== 6'h15 || ki !== 5'h0A) begin n_err++; $display("FAIL unlock_gains: got %h/%h want 15/0a", kp, ki); end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 15; i++) strobe(8'd50);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL tmo_early: got %0d want 2", state); end
    strobe(8'd50);
    n_cmp++; if (state !== 2'd1 || rst_o !== 1'b1 || en_o !== 1'b0) begin n_err++; $display("FAIL tmo_reset: got st=%0d rst=%b en=%b want 1 1 0", state, rst_o, en_o); end
    @(negedge clk);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL tmo_reset_len: got %0d want 1", state); end
    @(negedge clk);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL tmo_reacq: got %0d want 2", state); end
    for (int i = 0; i < 12; i++) strobe(8'd50);
    strobe(8'hFE); strobe(8'd2); strobe(8'hFE);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL tmo_lock15: got %0d want 2", state); end
    strobe(8'd2);
    n_cmp++; if (state !== 2'd3 || locked !== 1'b1) begin n_err++; $display("FAIL tmo_lock_wins: got st=%0d lk=%b want 3 1", state, locked); end
  endtask

  task automatic test_gain_resample;
    kp_trk = 6'h2A; ki_trk = 5'h11; kp_acq = 6'h3F;
    @(negedge clk);
    n_cmp++; if (kp !== 6'h2A || ki !== 5'h11) begin n_err++; $display("FAIL resample: got %h/%h want 2a/11", kp, ki); end
  endtask

  task automatic test_disable;
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (state !== 2'd0 || locked !== 1'b0) begin n_err++; $display("FAIL dis_state: got st=%0d lk=%b want 0 0", state, locked); end
    n_cmp++; if (kp !== 6'd0 || ki !== 5'd0 || en_o !== 1'b0 || rst_o !== 1'b1) begin n_err++; $display("FAIL dis_out: got %h/%h en=%b rst=%b want 0/0 0 1", kp, ki, en_o, rst_o); end
  endtask

  task automatic test_async_reset;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (state !== 2'd2 || kp !== 6'h3F) begin n_err++; $display("FAIL ar_pre: got st=%0d kp=%h want 2 3f", state, kp); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || rst_o !== 1'b1 || en_o !== 1'b0 || kp !== 6'd0) begin n_err++; $display("FAIL ar_now: got st=%0d rst=%b en=%b kp=%h want 0 1 0 0", state, rst_o, en_o, kp); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL ar_restart: got %0d want 1", state); end
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL ar_acq: got %0d want 2", state); end
  endtask

`ifdef ADPLL_RELOCK_CNT_EN
  task automatic test_relock_cnt;
    repeat (4) strobe(8'd0);
    for (int i = 0; i < 300; i++) begin
      strobe(8'h80); strobe(8'h80);
      if (i == 0) begin
        n_cmp++; if (relock !== 8'd1) begin n_err++; $display("FAIL relock_first: got %0d want 1", relock); end
      end
      repeat (4) strobe(8'd0);
    end
    n_cmp++; if (relock !== 8'd255 || state !== 2'd3) begin n_err++; $display("FAIL relock_sat: got %0d st=%0d want 255 3", relock, state); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (relock !== 8'd0) begin n_err++; $display("FAIL relock_clear: got %0d want 0", relock); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enable();
    test_lock();
    test_unlock();
    test_timeout();
    test_gain_resample();
    test_disable();
    test_async_reset();
`ifdef ADPLL_RELOCK_CNT_EN
    test_relock_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
